// File: rtl/rle_flash_fetch.sv
// QSPI fetch controller for the RLE video decoder: Quad Output Fast Read (0x6B) from
// ADDR_BASE, nibble assembly into 16-bit words, and a 2-entry word FIFO towards the decoder.
module rle_flash_fetch #(
    parameter logic [23:0] ADDR_BASE      = 24'h000000,
    parameter int          DUMMY_CYCLES   = 8,
    parameter int          CS_HIGH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        stop_data,
    input  logic        read_next,
    output logic        data_ready,
    output logic [15:0] data,
    output logic        spi_cs_n,
    output logic        spi_sck,
    output logic [3:0]  spi_d_out,
    output logic [3:0]  spi_d_oe,
    input  logic [3:0]  spi_d_in
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA} state_t;

    localparam logic [7:0] CMD_QOFR   = 8'h6B;
    localparam logic [4:0] CS_LAST    = 5'(CS_HIGH_CYCLES - 1);
    localparam logic [4:0] DUMMY_LAST = 5'(DUMMY_CYCLES - 1);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        sck_q, sck_d;
    logic        cs_n_q, cs_n_d;
    logic [3:0]  oe_q, oe_d;
    logic [23:0] sr_q, sr_d;
    logic [1:0]  count_q;
    logic        rd_ptr_q;
    logic        push, pop, flush;
    logic [11:0] word_q;
    logic [15:0] mem_q [2];

    // Command/address bits leave from the top of sr_q; it is all-zero outside CMD/ADDR.
    assign spi_cs_n   = cs_n_q;
    assign spi_sck    = sck_q;
    assign spi_d_oe   = oe_q;
    assign spi_d_out  = {3'b000, sr_q[23]};
    assign data_ready = (count_q != 2'd0);
    assign data       = data_ready ? mem_q[rd_ptr_q] : 16'h0000;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sck_q    <= 1'b0;
            cs_n_q   <= 1'b1;
            oe_q     <= '0;
            sr_q     <= '0;
            count_q  <= '0;
            rd_ptr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sck_q   <= sck_d;
            cs_n_q  <= cs_n_d;
            oe_q    <= oe_d;
            sr_q    <= sr_d;
            if (flush) begin
                count_q  <= '0;
                rd_ptr_q <= 1'b0;
            end else begin
                count_q  <= count_q + {1'b0, push} - {1'b0, pop};
                rd_ptr_q <= rd_ptr_q ^ pop;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sck_d   = sck_q;
        cs_n_d  = cs_n_q;
        oe_d    = oe_q;
        sr_d    = sr_q;
        push    = 1'b0;
        flush   = 1'b0;
        pop     = read_next && (count_q != 2'd0);
        case (state_q)
            IDLE: begin
                if (cnt_q == CS_LAST) begin
                    state_d = CMD;
                    cnt_d   = '0;
                    cs_n_d  = 1'b0;
                    oe_d    = 4'b0001;
                    sr_d    = {CMD_QOFR, 16'h0000};
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            CMD: begin
                sck_d = ~sck_q;
                if (sck_q) begin
                    cnt_d = cnt_q + 5'd1;
                    sr_d  = {sr_q[22:0], 1'b0};
                    if (cnt_q == 5'd7) begin
                        state_d = ADDR;
                        cnt_d   = '0;
                        sr_d    = ADDR_BASE;
                    end
                end
            end
            ADDR: begin
                sck_d = ~sck_q;
                if (sck_q) begin
                    cnt_d = cnt_q + 5'd1;
                    sr_d  = {sr_q[22:0], 1'b0};
                    if (cnt_q == 5'd23) begin
                        state_d = DUMMY;
                        cnt_d   = '0;
                        oe_d    = 4'b0000;
                    end
                end
            end
            DUMMY: begin
                sck_d = ~sck_q;
                if (sck_q) begin
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == DUMMY_LAST) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end
                end
            end
            DATA: begin
                if (!sck_q) begin
                    // A new word only begins when the FIFO has room; a started word always finishes.
                    if (cnt_q != 5'd0 || count_q != 2'd2)
                        sck_d = 1'b1;
                end else begin
                    sck_d = 1'b0;
                    if (cnt_q == 5'd3) begin
                        push  = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (stop_data) begin
            state_d = IDLE;
            cnt_d   = '0;
            sck_d   = 1'b0;
            cs_n_d  = 1'b1;
            oe_d    = 4'b0000;
            sr_d    = '0;
            push    = 1'b0;
            pop     = 1'b0;
            flush   = 1'b1;
        end
    end

    // Nibble assembly and FIFO storage carry no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (state_q == DATA && sck_q)
            word_q <= {word_q[7:0], spi_d_in};
        if (push)
            mem_q[rd_ptr_q ^ count_q[0]] <= {word_q, spi_d_in};
    end

endmodule

// File: tb/tb_rle_flash_fetch.sv
// Bench for rle_flash_fetch: behavioural QSPI flash, word scoreboard fed from the flash image,
// directed timing/flow-control checks and randomized pop traffic.
module tb_rle_flash_fetch;

    localparam int          D     = 8;
    localparam logic [23:0] ABASE = 24'h000000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        stop_data = 1'b0;
    logic        read_next = 1'b0;
    logic        data_ready;
    logic [15:0] data;
    logic        spi_cs_n, spi_sck;
    logic [3:0]  spi_d_out, spi_d_oe, spi_d_in;

    int tests = 0;
    int fails = 0;
    int pops = 0;
    int edges = 0;
    logic [7:0]  cmd_sh = '0;
    logic [23:0] addr_sh = '0;
    logic [7:0]  mem [256];
    logic [15:0] exp_q [$];

    rle_flash_fetch #(.ADDR_BASE(ABASE), .DUMMY_CYCLES(D), .CS_HIGH_CYCLES(2)) dut (
        .clk(clk), .rstn(rstn), .stop_data(stop_data), .read_next(read_next),
        .data_ready(data_ready), .data(data), .spi_cs_n(spi_cs_n), .spi_sck(spi_sck),
        .spi_d_out(spi_d_out), .spi_d_oe(spi_d_oe), .spi_d_in(spi_d_in)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected word stream: consecutive flash bytes from ADDR_BASE, lower address in the high byte.
    task automatic restart_expect();
        exp_q.delete();
        for (int k = 0; k < 128; k++)
            exp_q.push_back({mem[(2 * k) % 256], mem[(2 * k + 1) % 256]});
    endtask

    // Flash: count SCK rises per command, capture opcode/address, then stream nibbles.
    always @(posedge spi_sck or posedge spi_cs_n) begin
        if (spi_cs_n) begin
            edges = 0;
        end else begin
            if (edges < 8) cmd_sh = {cmd_sh[6:0], spi_d_out[0]};
            else if (edges < 32) addr_sh = {addr_sh[22:0], spi_d_out[0]};
            edges++;
            if (edges == 32) begin
                check("flash_cmd", 32'(cmd_sh), 32'h6B);
                check("flash_addr", 32'(addr_sh), 32'(ABASE));
            end
        end
    end

    function automatic logic [3:0] flash_nibble(input int e);
        int n;
        logic [7:0] b;
        if (e < 33 + D) return 4'h0;
        n = e - 33 - D;
        b = mem[(n / 2) % 256];
        return (n % 2 == 0) ? b[7:4] : b[3:0];
    endfunction

    assign spi_d_in = flash_nibble(edges);

    // Scoreboard monitor: every accepted pop must deliver the next expected word.
    always @(negedge clk) begin
        if (rstn && data_ready && read_next) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_underflow: got %0h, expected no word", data);
            end else begin
                check("sb_word", 32'(data), 32'(exp_q.pop_front()));
            end
            pops++;
        end
    end

    // Bus invariants.
    always @(negedge clk) begin
        if (rstn) begin
            if (spi_cs_n && spi_sck) begin
                fails++;
                $display("FAIL inv_sck_cs: sck=%0b while cs_n=%0b", spi_sck, spi_cs_n);
            end
            if (spi_d_oe != 4'h0 && (spi_cs_n || edges > 32 || (edges == 32 && !spi_sck))) begin
                fails++;
                $display("FAIL inv_oe: oe=%0h at edge %0d", spi_d_oe, edges);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!data_ready && n < 500) begin
            tick();
            n++;
        end
        if (!data_ready) begin
            tests++;
            fails++;
            $display("FAIL %s: data_ready=0, required 1 within 500 clk", name);
        end
    endtask

    task automatic measure_start(input string tag);
        int n = 0;
        int m = 0;
        while (spi_cs_n && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_cs_fall"}, 32'(n), 32'd2);
        while (!data_ready && m < 200) begin
            tick();
            m++;
        end
        check({tag, "_first_ready"}, 32'(m), 32'd88);
        check({tag, "_first_word"}, 32'(data), 32'h0ABC);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cs_n"}, 32'(spi_cs_n), 32'd1);
        check({tag, "_sck"}, 32'(spi_sck), 32'd0);
        check({tag, "_d_out"}, 32'(spi_d_out), 32'd0);
        check({tag, "_d_oe"}, 32'(spi_d_oe), 32'd0);
        check({tag, "_ready"}, 32'(data_ready), 32'd0);
        check({tag, "_data"}, 32'(data), 32'd0);
    endtask

    initial begin
        int target;
        int n;
        mem[0] = 8'h0A; mem[1] = 8'hBC; mem[2] = 8'h12; mem[3] = 8'h34;
        for (int i = 4; i < 256; i++) mem[i] = 8'($urandom);
        restart_expect();

        // 1: reset state and first command/word timing
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rstn = 1'b1;
        measure_start("start");

        // 2: no pops, FIFO fills to two words and SCK stalls
        repeat (200) tick();
        check("stall_data", 32'(data), 32'h0ABC);
        check("stall_ready", 32'(data_ready), 32'd1);
        check("stall_sck", 32'(spi_sck), 32'd0);
        check("stall_cs_n", 32'(spi_cs_n), 32'd0);
        check("stall_edges", 32'(edges), 32'(32 + D + 8));
        read_next = 1'b1;
        tick();
        read_next = 1'b0;
        check("pop_next_word", 32'(data), 32'h1234);
        repeat (4) tick();
        check("sck_resumed", 32'(edges > 32 + D + 8), 32'd1);

        // 3: pop every cycle for 64 words
        target = pops + 64;
        read_next = 1'b1;
        n = 0;
        while (pops < target && n < 2000) begin
            tick();
            n++;
        end
        read_next = 1'b0;
        check("stream_64_words", 32'(pops >= target), 32'd1);

        // 4: restart, stop_data mid-word 3, stray pop
        stop_data = 1'b1;
        tick();
        stop_data = 1'b0;
        restart_expect();
        wait_ready("restart_ready");
        read_next = 1'b1;
        tick();
        read_next = 1'b0;
        n = 0;
        while (edges < 33 + D + 9 && n < 100) begin
            tick();
            n++;
        end
        check("reached_word3", 32'(edges), 32'(33 + D + 9));
        stop_data = 1'b1;
        tick();
        stop_data = 1'b0;
        check_idle_outputs("stop");
        restart_expect();
        tick();
        read_next = 1'b1;
        tick();
        read_next = 1'b0;
        check("stray_pop_ready", 32'(data_ready), 32'd0);
        wait_ready("after_stop_ready");
        check("after_stop_word", 32'(data), 32'h0ABC);

        // 5: pop of word 0 coincides with push of word 1 (count=1)
        n = 0;
        while (!(spi_sck && edges == 32 + D + 8) && n < 100) begin
            tick();
            n++;
        end
        read_next = 1'b1;
        tick();
        check("same_cycle_data", 32'(data), 32'h1234);
        check("same_cycle_ready", 32'(data_ready), 32'd1);
        tick();
        read_next = 1'b0;
        check("same_cycle_count1", 32'(data_ready), 32'd0);

        // random pop traffic, then asynchronous reset mid-DATA
        for (int i = 0; i < 300; i++) begin
            read_next = 1'($urandom_range(0, 1));
            tick();
        end
        read_next = 1'b0;
        #3;
        rstn = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        repeat (3) @(posedge clk);
        restart_expect();
        #1;
        rstn = 1'b1;
        measure_start("rerun");
        for (int i = 0; i < 400; i++) begin
            read_next = 1'($urandom_range(0, 1));
            tick();
        end
        read_next = 1'b0;
        repeat (2) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
